tt_um_trit_unpack: RTL

Upstream stage of the weight register file. Accepts a byte stream of base-3 packed ternary weights, 5 trits per byte, from the pin-level input path. Emits one signed 2-bit weight per handshake, with its flat index, to the weight loader.
Packing cuts pin transfer cost from 4 weights/byte to 5 weights/byte. Decoding is sequential: one divide-by-3 step per emitted trit.

---
 rtl/tt_ternary_pkg.sv | 23 ++
 rtl/tt_um_divmod3.sv | 17 +
 rtl/tt_um_trit_unpack.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tt_ternary_pkg.sv
// Shared ternary-weight definitions: trit encodings, packing limits, unpacker states.
package tt_ternary_pkg;

  localparam logic [1:0] TRIT_ZERO = 2'b00;
  localparam logic [1:0] TRIT_POS  = 2'b01;
  localparam logic [1:0] TRIT_NEG  = 2'b11;

  // Largest byte that encodes five base-3 digits (22222 in base 3).
  localparam logic [7:0] PACK_MAX       = 8'd242;
  localparam int         TRITS_PER_BYTE = 5;

  typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_e;

  // Base-3 digit to signed 2-bit weight.
  function automatic logic [1:0] trit_enc(input logic [1:0] dig);
    case (dig)
      2'd1:    trit_enc = TRIT_POS;
      2'd2:    trit_enc = TRIT_NEG;
      default: trit_enc = TRIT_ZERO;
    endcase
  endfunction

endpackage

// File: rtl/tt_um_divmod3.sv
// Combinational 8-bit divide-by-3; residues fed here are always below 243,
// and even 255/3 fits the 7-bit quotient.
module tt_um_divmod3 (
  input  logic [7:0] a,
  output logic [6:0] q,
  output logic [1:0] r
);

  logic [7:0] quo_full;
  logic [7:0] rem_full;

  assign quo_full = a / 8'd3;
  assign rem_full = a % 8'd3;
  assign q        = quo_full[6:0];
  assign r        = rem_full[1:0];

endmodule

// File: rtl/tt_um_trit_unpack.sv
// Unpacks base-3 packed bytes (5 trits/byte) into a stream of signed 2-bit
// weights with flat indices. One trit is peeled off per accepted weight.
module tt_um_trit_unpack
  import tt_ternary_pkg::*;
#(
  parameter  int MAX_IN_LEN  = 16,
  parameter  int MAX_OUT_LEN = 8,
  localparam int NUM_W       = MAX_IN_LEN * MAX_OUT_LEN,
  localparam int IDX_W       = $clog2(NUM_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W:0]   cfg_count,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       w_data,
  output logic             w_valid,
  input  logic             w_ready,
  output logic [IDX_W-1:0] w_index,
  output logic             done,
  output logic             err
);

  localparam logic [IDX_W:0] CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [2:0]     DIG_LAST = 3'(TRITS_PER_BYTE - 1);

  state_e           state_q, state_d;
  logic [IDX_W:0]   cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [7:0]       res_q;
  logic [2:0]       dig_q;
  logic             err_q;
  logic [6:0]       quo;
  logic [1:0]       rem;
  logic             byte_ok;
  logic             last_w;

  tt_um_divmod3 u_div (
    .a (res_q),
    .q (quo),
    .r (rem)
  );

  assign byte_ok = (in_data <= PACK_MAX);
  assign last_w  = ({1'b0, idx_q} == (cnt_q - CNT_ONE));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs; abort overrides everything and
  // suppresses handshakes so nothing is taken or offered in that cycle.
  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    w_valid  = 1'b0;
    unique case (state_q)
      IDLE, DONE: if (start) state_d = (cfg_count == '0) ? DONE : FETCH;
      FETCH: begin
        in_ready = 1'b1;
        if (in_valid && byte_ok) state_d = EMIT;
      end
      EMIT: begin
        w_valid = 1'b1;
        if (w_ready) begin
          if (last_w)                state_d = DONE;
          else if (dig_q == DIG_LAST) state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d  = IDLE;
      in_ready = 1'b0;
      w_valid  = 1'b0;
    end
  end

  // Datapath: count latch, byte residue, digit and index counters, sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      idx_q <= '0;
      res_q <= '0;
      dig_q <= '0;
      err_q <= 1'b0;
    end else if (abort) begin
      idx_q <= '0;
      err_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, DONE: if (start) begin
          cnt_q <= cfg_count;
          idx_q <= '0;
          err_q <= 1'b0;
        end
        FETCH: if (in_valid) begin
          if (byte_ok) begin
            res_q <= in_data;
            dig_q <= '0;
          end else begin
            err_q <= 1'b1;
          end
        end
        EMIT: if (w_ready) begin
          res_q <= {1'b0, quo};
          dig_q <= dig_q + 3'd1;
          idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // w_data depends only on registered residue, never on w_ready.
  assign w_data  = (state_q == EMIT) ? trit_enc(rem) : TRIT_ZERO;
  assign w_index = idx_q;
  assign done    = (state_q == DONE);
  assign err     = err_q;

endmodule
